video_timing: RTL and testbench
===============================

# video_timing

Raster timing generator that drives the character/attribute text buffer and the colour output stage. It counts raw pixel/line positions for a VGA-style mode. It produces sync pulses and decodes a centred, integer-upscaled logical window into the logical coordinates `hpos` (0–159) and `vpos` (0–127) that the text buffer consumes. All outputs are registered and advance only on pixel-clock-enable cycles.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, active lines
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BACK`, 33, vertical back porch
- `SYNC_POL`, 0, sync active level (0 = active-low)
- `SCALE`, 3, raw pixels/lines per logical pixel/line
- `LOG_W`, 160, logical window width
- `LOG_H`, 128, logical window height
- `X_OFF`, 80, first raw column of window
- `Y_OFF`, 48, first raw line of window

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `ce` in 1: pixel clock enable; all state advances only when high
- `hsync` out 1: horizontal sync at `SYNC_POL`
- `vsync` out 1: vertical sync at `SYNC_POL`
- `display_on` out 1: raw position inside visible area
- `window_on` out 1: raw position inside logical window
- `hpos` out 8: logical column
- `vpos` out 7: logical line
- `hcount` out 10: raw column
- `vcount` out 10: raw line
- `frame_start` out 1: one-`clk` pulse at raw (0,0)

## Operation
- `H_TOTAL` = sum of the H_* parameters (800); `V_TOTAL` = sum of the V_* parameters (525).
- `hcount` runs 0..H_TOTAL-1 and then wraps to 0. At the wrap, `vcount` increments, wrapping at V_TOTAL-1 → 0.
- Sync regions:
  - `hsync` is active for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
  - `vsync` is active for vcount in [490,491].
- `display_on` = hcount < H_VISIBLE && vcount < V_VISIBLE.
- `window_on` = hcount in [X_OFF, X_OFF+LOG_W*SCALE-1] = [80,559] && vcount in [Y_OFF, Y_OFF+LOG_H*SCALE-1] = [48,431].
- Logical coordinates come from sub-counters `sx`/`sy` (0..SCALE-1); no dividers.
  - Horizontal: `sx` and `hpos` are cleared at hcount = X_OFF. Each ce inside the window increments `sx`; when `sx` = SCALE-1 it wraps to 0 and `hpos` increments.
  - Outside the horizontal window, `hpos` = 0.
  - Vertical: `sy` and `vpos` are cleared at vcount = Y_OFF. At each line wrap inside the window, `sy` steps; `vpos` increments when `sy` wraps.
  - Outside the vertical window, `vpos` = 0. `vpos` is constant across an entire raw line.
- `hpos` never exceeds LOG_W-1 and `vpos` never exceeds LOG_H-1. Do not rely on 8-bit/7-bit wrap.
- `frame_start` is high for exactly the one `clk` cycle in which registered hcount = vcount = 0 is first presented after a ce.
- All outputs are registered. Each output's value corresponds to the same raw position as `hcount`/`vcount`, meaning it is computed from the next counter values.

## Timing
- Reset (asynchronous, immediate): hcount = vcount = 0; `sx` = `sy` = 0; hpos = vpos = 0.
  - Syncs go inactive (`!SYNC_POL`).
  - `display_on` = 1 (position (0,0) is visible).
  - `window_on` = 0; `frame_start` = 0.
- First ce after reset release moves to (1,0). `frame_start` asserts only at the next wrap to (0,0).
- Reset asserted mid-frame returns immediately to the reset state. No partial sync pulse continues.
- `ce` low: all registers hold, except that `frame_start` clears after one cycle.
- Latency: zero cycles between the counter state and the decoded outputs, since they are updated on the same edge.
- Simultaneous end of line and end of frame (799,524): the next ce produces (0,0), `frame_start` = 1, and `vpos` = 0.

## Test plan
- **Reset mid-line:** assert reset at hcount = 300 → all outputs at reset values within the same cycle; with ce held high after release, hcount = 5 after 5 clocks.
- **Horizontal sync:** ce = 1 continuously → `hsync` low for exactly 96 cycles starting at hcount = 656; line period is 800 cycles.
- **Vertical sync and frame:** run a full frame → `vsync` low for exactly lines 490–491, i.e. 1600 ce cycles. `frame_start` pulses exactly once per 420000 ce cycles.
- **Window mapping:** at vcount = 48:
  - hcount 80/81/82 → hpos 0, 83 → hpos 1, 559 → hpos 159;
  - hcount 560 → `window_on` = 0, hpos = 0.
  - At vcount 431, vpos = 127; at vcount 432, vpos = 0.
- **ce gating:** ce toggling 1/0 → counters advance every other clock and the sync widths double in clocks. With ce = 0 for 50 clocks, all outputs remain stable.
- **Parameter override:** SCALE = 2, LOG_W = 160, X_OFF = 160 → hpos increments every 2 ce cycles; hpos = 159 at hcount = 478.

Source files
------------

// File: rtl/video_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : video_timing
// Purpose  : VGA-style raster timing generator. Counts raw pixel/line
//            positions, generates sync pulses, and maps a centred,
//            integer-upscaled logical window onto logical coordinates
//            (hpos, vpos) for the text buffer.
// Ports    : clk, reset (async, active-high), ce (pixel clock enable)
//            hsync, vsync      - sync pulses at SYNC_POL
//            display_on        - raw position inside the visible area
//            window_on         - raw position inside the logical window
//            hpos, vpos        - logical column / line
//            hcount, vcount    - raw column / line
//            frame_start       - one-clk pulse when (0,0) is presented
// Revision : 1.0 - initial release
// ============================================================================
module video_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int SCALE     = 3,
    parameter int LOG_W     = 160,
    parameter int LOG_H     = 128,
    parameter int X_OFF     = 80,
    parameter int Y_OFF     = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       window_on,
    output logic [7:0] hpos,
    output logic [6:0] vpos,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       frame_start
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [9:0] c_H_LAST  = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST  = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_HS_BEG  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_BEG  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] c_H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] c_X_BEG   = 10'(X_OFF);
    localparam logic [9:0] c_X_END   = 10'(X_OFF + LOG_W * SCALE - 1);
    localparam logic [9:0] c_Y_BEG   = 10'(Y_OFF);
    localparam logic [9:0] c_Y_END   = 10'(Y_OFF + LOG_H * SCALE - 1);
    localparam logic [c_SW-1:0] c_S_LAST  = c_SW'(SCALE - 1);
    localparam logic [c_SW-1:0] c_S_ONE   = c_SW'(1);
    localparam logic [7:0] c_HPOS_LAST = 8'(LOG_W - 1);
    localparam logic [6:0] c_VPOS_LAST = 7'(LOG_H - 1);

    logic [c_SW-1:0] r_sx;
    logic [c_SW-1:0] r_sy;

    logic       w_hwrap;
    logic [9:0] w_hnext;
    logic [9:0] w_vnext;
    logic       w_in_x;
    logic       w_in_y;

    // Every registered output is decoded from the next counter values so
    // that all outputs describe the same raw position as hcount/vcount.
    always_comb begin
        w_hwrap = (hcount == c_H_LAST);
        w_hnext = w_hwrap ? 10'd0 : hcount + 10'd1;
        w_vnext = vcount;
        if (w_hwrap) begin
            w_vnext = (vcount == c_V_LAST) ? 10'd0 : vcount + 10'd1;
        end
        w_in_x = (w_hnext >= c_X_BEG) && (w_hnext <= c_X_END);
        w_in_y = (w_vnext >= c_Y_BEG) && (w_vnext <= c_Y_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount      <= 10'd0;
            vcount      <= 10'd0;
            r_sx        <= '0;
            r_sy        <= '0;
            hpos        <= 8'd0;
            vpos        <= 7'd0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            display_on  <= 1'b1;
            window_on   <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hcount      <= w_hnext;
            vcount      <= w_vnext;
            hsync       <= (w_hnext >= c_HS_BEG && w_hnext <= c_HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (w_vnext >= c_VS_BEG && w_vnext <= c_VS_END) ? SYNC_POL : ~SYNC_POL;
            display_on  <= (w_hnext < c_H_VIS) && (w_vnext < c_V_VIS);
            window_on   <= w_in_x && w_in_y;
            frame_start <= (w_hnext == 10'd0) && (w_vnext == 10'd0);

            // Horizontal sub-pixel counter: restart at the window's left
            // edge, step once per raw pixel, bump hpos every SCALE pixels.
            if (!w_in_x || (w_hnext == c_X_BEG)) begin
                r_sx <= '0;
                hpos <= 8'd0;
            end else if (r_sx == c_S_LAST) begin
                r_sx <= '0;
                if (hpos != c_HPOS_LAST) begin
                    hpos <= hpos + 8'd1;
                end
            end else begin
                r_sx <= r_sx + c_S_ONE;
            end

            // Vertical sub-line counter only moves at line wrap, which keeps
            // vpos constant across a whole raw line.
            if (w_hwrap) begin
                if (!w_in_y || (w_vnext == c_Y_BEG)) begin
                    r_sy <= '0;
                    vpos <= 7'd0;
                end else if (r_sy == c_S_LAST) begin
                    r_sy <= '0;
                    if (vpos != c_VPOS_LAST) begin
                        vpos <= vpos + 7'd1;
                    end
                end else begin
                    r_sy <= r_sy + c_S_ONE;
                end
            end
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_video_timing
// Purpose  : Self-checking bench for video_timing. Three instances: the
//            default VGA mode, a tiny mode (full frames in a few hundred
//            clocks, active-high syncs) and a SCALE=2 / X_OFF=160 override.
//            Each is compared every clock against an arithmetic raster model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       disp;
        logic       win;
        logic       fs;
        logic [7:0] hpos;
        logic [6:0] vpos;
        logic [9:0] hc;
        logic [9:0] vc;
    } obs_t;

    typedef struct {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        bit pol;
        int sc, lw, lh, xo, yo;
    } cfg_t;

    typedef struct {
        bit r;
        bit c;
        int h;
        int v;
        bit fs;
    } vec_t;

    logic hs0, vs0, do0, wo0, fs0; logic [7:0] hp0; logic [6:0] vp0; logic [9:0] hc0, vc0;
    logic hs1, vs1, do1, wo1, fs1; logic [7:0] hp1; logic [6:0] vp1; logic [9:0] hc1, vc1;
    logic hs2, vs2, do2, wo2, fs2; logic [7:0] hp2; logic [6:0] vp2; logic [9:0] hc2, vc2;

    video_timing u_d0 (
        .clk(clk), .reset(reset), .ce(ce), .hsync(hs0), .vsync(vs0),
        .display_on(do0), .window_on(wo0), .hpos(hp0), .vpos(vp0),
        .hcount(hc0), .vcount(vc0), .frame_start(fs0)
    );

    video_timing #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b1), .SCALE(2), .LOG_W(4), .LOG_H(3), .X_OFF(4), .Y_OFF(3)
    ) u_d1 (
        .clk(clk), .reset(reset), .ce(ce), .hsync(hs1), .vsync(vs1),
        .display_on(do1), .window_on(wo1), .hpos(hp1), .vpos(vp1),
        .hcount(hc1), .vcount(vc1), .frame_start(fs1)
    );

    video_timing #(
        .SCALE(2), .LOG_W(160), .X_OFF(160)
    ) u_d2 (
        .clk(clk), .reset(reset), .ce(ce), .hsync(hs2), .vsync(vs2),
        .display_on(do2), .window_on(wo2), .hpos(hp2), .vpos(vp2),
        .hcount(hc2), .vcount(vc2), .frame_start(fs2)
    );

    cfg_t cfg[3];
    int   mh[3];
    int   mv[3];
    bit   mfs[3];
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[9];

    // Expected outputs at raw position (h,v), straight from the raster rules.
    function automatic obs_t model(cfg_t c, int h, int v, bit fs);
        obs_t e;
        int   hsb, vsb;
        bit   inx, iny;
        hsb    = c.hv + c.hf;
        vsb    = c.vv + c.vf;
        inx    = (h >= c.xo) && (h < c.xo + c.lw * c.sc);
        iny    = (v >= c.yo) && (v < c.yo + c.lh * c.sc);
        e.hs   = (h >= hsb && h < hsb + c.hs) ? c.pol : !c.pol;
        e.vs   = (v >= vsb && v < vsb + c.vs) ? c.pol : !c.pol;
        e.disp = (h < c.hv) && (v < c.vv);
        e.win  = inx && iny;
        e.fs   = fs;
        e.hpos = inx ? 8'((h - c.xo) / c.sc) : 8'd0;
        e.vpos = iny ? 7'((v - c.yo) / c.sc) : 7'd0;
        e.hc   = 10'(h);
        e.vc   = 10'(v);
        return e;
    endfunction

    function automatic obs_t get(int i);
        obs_t o;
        case (i)
            0:       o = '{hs0, vs0, do0, wo0, fs0, hp0, vp0, hc0, vc0};
            1:       o = '{hs1, vs1, do1, wo1, fs1, hp1, vp1, hc1, vc1};
            default: o = '{hs2, vs2, do2, wo2, fs2, hp2, vp2, hc2, vc2};
        endcase
        return o;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d at (%0d,%0d)", i, mh[i], mv[i]),
                64'(get(i)), 64'(model(cfg[i], mh[i], mv[i], mfs[i])));
        end
    endtask

    // Drive inputs, let one rising edge pass, advance the model, and
    // return at the falling edge where outputs are sampled.
    task automatic tick(bit r, bit c);
        int ht, vt;
        reset = r;
        ce    = c;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            ht = cfg[i].hv + cfg[i].hf + cfg[i].hs + cfg[i].hb;
            vt = cfg[i].vv + cfg[i].vf + cfg[i].vs + cfg[i].vb;
            if (r) begin
                mh[i] = 0; mv[i] = 0; mfs[i] = 1'b0;
            end else if (c) begin
                mh[i]++;
                if (mh[i] == ht) begin
                    mh[i] = 0;
                    mv[i]++;
                    if (mv[i] == vt) mv[i] = 0;
                end
                mfs[i] = (mh[i] == 0) && (mv[i] == 0);
            end else begin
                mfs[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int  cnt, fcnt;
        bit  reached;

        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 3, 160, 128, 80, 48};
        cfg[1] = '{16, 2, 4, 2, 12, 2, 2, 2, 1'b1, 2, 4, 3, 4, 3};
        cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2, 160, 128, 160, 48};
        for (int i = 0; i < 3; i++) begin
            mh[i] = 0; mv[i] = 0; mfs[i] = 1'b0;
        end

        vecs[0] = '{1'b1, 1'b1, 0, 0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 0, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 0, 0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1, 0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 2, 0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 2, 0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 3, 0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 0, 0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1, 0, 1'b0};

        reset = 1'b1;
        ce    = 1'b0;
        @(negedge clk);

        // Table-driven start-up vectors
        for (int k = 0; k < 9; k++) begin
            tick(vecs[k].r, vecs[k].c);
            chk($sformatf("vec%0d hcount", k), 64'(hc0), 64'(vecs[k].h));
            chk($sformatf("vec%0d vcount", k), 64'(vc0), 64'(vecs[k].v));
            chk($sformatf("vec%0d frame_start", k), 64'(fs0), 64'(vecs[k].fs));
            check_all();
        end

        // Asynchronous reset in the middle of a line
        tick(1'b1, 1'b0);
        repeat (300) tick(1'b0, 1'b1);
        chk("pre-reset hcount", 64'(hc0), 64'd300);
        reset = 1'b1;
        #1;
        chk("async reset hcount", 64'(hc0), 64'd0);
        chk("async reset hsync", 64'(hs0), 64'd1);
        chk("async reset display_on", 64'(do0), 64'd1);
        chk("async reset window_on", 64'(wo0), 64'd0);
        chk("async reset hpos", 64'(hp0), 64'd0);
        chk("async reset vsync small", 64'(vs1), 64'd0);
        tick(1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b1);
        chk("hcount 5 clocks after reset", 64'(hc0), 64'd5);
        check_all();

        // Random ce until the default mode has passed window line 48
        tick(1'b1, 1'b0);
        reached = 1'b0;
        for (int n = 0; n < 80000 && !reached; n++) begin
            tick(1'b0, $urandom_range(3) != 0);
            check_all();
            if (mv[0] == 48) begin
                case (mh[0])
                    80, 81, 82: chk($sformatf("hpos at h=%0d", mh[0]), 64'(hp0), 64'd0);
                    83:         chk("hpos at h=83", 64'(hp0), 64'd1);
                    559:        chk("hpos at h=559", 64'(hp0), 64'd159);
                    560:        chk("win/hpos at h=560", 64'({wo0, hp0}), 64'd0);
                    default: ;
                endcase
            end
            if (mh[2] == 478) chk("override hpos at h=478", 64'(hp2), 64'd159);
            if (mv[1] == 8)   chk("small vpos last window line", 64'(vp1), 64'd2);
            if (mv[1] == 9)   chk("small vpos below window", 64'(vp1), 64'd0);
            if (mv[0] == 49)  reached = 1'b1;
        end
        if (!reached) chk("random phase reached line 49", 64'(mv[0]), 64'd49);

        // ce toggling: one full line takes 1600 clocks, hsync spans 192
        cnt = 0;
        for (int k = 0; k < 1600; k++) begin
            tick(1'b0, (k % 2) == 0);
            check_all();
            if (!hs0) cnt++;
        end
        chk("hsync clocks at half rate", 64'(cnt), 64'd192);

        // ce held low: everything holds, frame_start stays clear
        repeat (50) begin
            tick(1'b0, 1'b0);
            check_all();
        end

        // Full rate: one default line and one small frame
        cnt = 0;
        for (int k = 0; k < 800; k++) begin
            tick(1'b0, 1'b1);
            check_all();
            if (!hs0) cnt++;
        end
        chk("hsync clocks per line", 64'(cnt), 64'd96);

        cnt  = 0;
        fcnt = 0;
        for (int k = 0; k < 432; k++) begin
            tick(1'b0, 1'b1);
            check_all();
            if (vs1) cnt++;
            if (fs1) fcnt++;
        end
        chk("small vsync clocks per frame", 64'(cnt), 64'd48);
        chk("small frame_start per frame", 64'(fcnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
